// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants, arctangent table and FSM states for the rotation CORDIC
package cordic_pkg;
    localparam int ITER = 12;
    localparam int ATAN [ITER] = '{3217, 1899, 1003, 509, 256, 128, 64, 32, 16, 8, 4, 2};
    localparam int K_GAIN = 2487;
    localparam int PI_Q = 12868;
    localparam int PI_2_Q = 6434;
    typedef enum logic [1:0] {IDLE, ROT, SCALE, DONE} state_t;
endpackage

// File: rtl/cordic_rotate_if.sv
// cordic_rotate_if: operand and result handshakes of the rotation CORDIC
interface cordic_rotate_if #(parameter int DATA_WIDTH = 15);
    logic in_valid;
    logic in_ready;
    logic signed [DATA_WIDTH-1:0] in_mag;
    logic signed [DATA_WIDTH-1:0] in_theta;
    logic out_valid;
    logic out_ready;
    logic signed [DATA_WIDTH-1:0] out_X;
    logic signed [DATA_WIDTH-1:0] out_Y;
    logic signed [DATA_WIDTH-1:0] out_theta_res;
    modport master (output in_valid, in_mag, in_theta, out_ready,
                    input in_ready, out_valid, out_X, out_Y, out_theta_res);
    modport slave (input in_valid, in_mag, in_theta, out_ready,
                   output in_ready, out_valid, out_X, out_Y, out_theta_res);
endinterface

// File: rtl/cordic_rot_iter.sv
// cordic_rot_iter: one combinational micro-rotation, steered by the sign of the residual angle
module cordic_rot_iter #(
    parameter int XW = 17,
    parameter int ZW = 15
) (
    input  logic signed [XW-1:0] x,
    input  logic signed [XW-1:0] y,
    input  logic signed [ZW-1:0] z,
    input  logic        [3:0]    i,
    input  logic signed [ZW-1:0] atan_i,
    output logic signed [XW-1:0] x_n,
    output logic signed [XW-1:0] y_n,
    output logic signed [ZW-1:0] z_n
);
    logic pos;
    assign pos = !z[ZW-1];
    assign x_n = pos ? x - (y >>> i) : x + (y >>> i);
    assign y_n = pos ? y + (x >>> i) : y - (x >>> i);
    assign z_n = pos ? z - atan_i : z + atan_i;
endmodule

// File: rtl/cordic_rotate.sv
// cordic_rotate: iterative polar-to-rectangular CORDIC with gain compensation and valid/ready handshakes
module cordic_rotate
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH = 15,
    parameter int GUARD = 2
) (
    input logic clk,
    input logic rst,
    cordic_rotate_if.slave bus
);
    localparam int XW = DATA_WIDTH + GUARD;
    localparam int PW = XW + 13;
    localparam logic signed [DATA_WIDTH-1:0] MAXV = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] MINV = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t state, state_n;
    logic signed [XW-1:0] x, y, x_n, y_n, x0;
    logic signed [DATA_WIDTH-1:0] z, z_n, z0, atan_i;
    logic [3:0] i;
    logic flip_hi, flip_lo, last;
    logic signed [PW-1:0] px, py;
    logic out_valid;
    logic signed [DATA_WIDTH-1:0] out_x, out_y, out_res;

    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] s;
        s = p >>> 12;
        return s > PW'(MAXV) ? MAXV : s < PW'(MINV) ? MINV : s[DATA_WIDTH-1:0];
    endfunction

    // angles beyond +-pi/2 are folded by pi with the magnitude negated
    assign flip_hi = bus.in_theta > DATA_WIDTH'(PI_2_Q);
    assign flip_lo = bus.in_theta < -DATA_WIDTH'(PI_2_Q);
    assign z0 = flip_hi ? bus.in_theta - DATA_WIDTH'(PI_Q)
              : flip_lo ? bus.in_theta + DATA_WIDTH'(PI_Q) : bus.in_theta;
    assign x0 = (flip_hi || flip_lo) ? -XW'(bus.in_mag) : XW'(bus.in_mag);
    assign atan_i = DATA_WIDTH'(ATAN[i]);
    assign last = i == 4'(ITER - 1);
    assign px = PW'(x) * PW'(K_GAIN);
    assign py = PW'(y) * PW'(K_GAIN);

    assign bus.in_ready = state == IDLE;
    assign bus.out_valid = out_valid;
    assign bus.out_X = out_x;
    assign bus.out_Y = out_y;
    assign bus.out_theta_res = out_res;

    cordic_rot_iter #(.XW(XW), .ZW(DATA_WIDTH)) u_iter (
        .x(x), .y(y), .z(z), .i(i), .atan_i(atan_i),
        .x_n(x_n), .y_n(y_n), .z_n(z_n)
    );

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_n;
    end

    // sequencing: accept, iterate ITER times, scale once, wait for the consumer
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.in_valid ? ROT : IDLE;
            ROT:     state_n = last ? SCALE : ROT;
            SCALE:   state_n = DONE;
            DONE:    state_n = bus.out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    // datapath: load pre-rotated operand, micro-rotate, gain-compensate and hold the result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x <= '0;
            y <= '0;
            z <= '0;
            i <= '0;
            out_x <= '0;
            out_y <= '0;
            out_res <= '0;
            out_valid <= 1'b0;
        end else begin
            if (state == IDLE && bus.in_valid) begin
                x <= x0;
                y <= '0;
                z <= z0;
                i <= '0;
            end
            if (state == ROT) begin
                x <= x_n;
                y <= y_n;
                z <= z_n;
                i <= last ? 4'd0 : i + 4'd1;
            end
            if (state == SCALE) begin
                out_x <= sat(px);
                out_y <= sat(py);
                out_res <= z;
                out_valid <= 1'b1;
            end
            if (state == DONE && bus.out_ready) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cordic_rotate.sv
// tb_cordic_rotate: scoreboard bench comparing the CORDIC against trigonometric expectations
module tb_cordic_rotate;
    localparam int DW = 15;

    typedef struct {
        real ex;
        real ey;
        real tol;
        int  acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    bit seen = 1'b0;

    cordic_rotate_if #(.DATA_WIDTH(DW)) bus();
    cordic_rotate #(.DATA_WIDTH(DW), .GUARD(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // cycle counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    function automatic real clampr(input real v);
        return v > 16383.0 ? 16383.0 : v < -16384.0 ? -16384.0 : v;
    endfunction

    function automatic real absr(input real v);
        return v < 0.0 ? -v : v;
    endfunction

    task automatic chk(input string name, input bit ok, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic send(input int m, input int t, input real tol);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("in_ready_timeout", n < 50, n, 50);
        bus.in_mag = DW'(m);
        bus.in_theta = DW'(t);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        sb.push_back('{clampr(m * $cos(t / 4096.0)), clampr(m * $sin(t / 4096.0)), tol, cyc});
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !bus.in_ready) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", n < 100, n, 100);
    endtask

    // monitor: score each result on the cycle it is first presented
    always @(negedge clk) begin
        exp_t e;
        if (!bus.out_valid) seen = 1'b0;
        else if (!seen) begin
            seen = 1'b1;
            if (sb.size() == 0) chk("unexpected_result", 1'b0, bus.out_X, 0);
            else begin
                e = sb.pop_front();
                chk("out_X", absr(real'(bus.out_X) - e.ex) <= e.tol, bus.out_X, $rtoi(e.ex));
                chk("out_Y", absr(real'(bus.out_Y) - e.ey) <= e.tol, bus.out_Y, $rtoi(e.ey));
                chk("theta_res", bus.out_theta_res >= -2 && bus.out_theta_res <= 2,
                    bus.out_theta_res, 0);
                chk("latency", cyc - e.acc == 13, cyc - e.acc, 13);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        int t;
        real hx;
        bus.in_valid = 1'b0;
        bus.in_mag = '0;
        bus.in_theta = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready == 1'b1, bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid == 1'b0, bus.out_valid, 0);
        chk("rst_out_X", bus.out_X == 0, bus.out_X, 0);
        chk("rst_out_Y", bus.out_Y == 0, bus.out_Y, 0);
        chk("rst_theta_res", bus.out_theta_res == 0, bus.out_theta_res, 0);
        rst = 1'b1;

        send(4096, 0, 4.0);
        send(4096, 3217, 4.0);
        send(4096, -9651, 4.0);
        send(4096, 12868, 4.0);
        drain();

        bus.out_ready = 1'b0;
        send(4096, 3217, 4.0);
        repeat (3) @(posedge clk);
        #1;
        chk("in_ready_rot", bus.in_ready == 1'b0, bus.in_ready, 0);
        bus.in_mag = DW'(1234);
        bus.in_theta = DW'(-777);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_timeout", n < 30, n, 30);
        hx = 4096 * $cos(3217 / 4096.0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_valid", bus.out_valid == 1'b1, bus.out_valid, 1);
            chk("hold_X", absr(real'(bus.out_X) - hx) <= 4.0, bus.out_X, $rtoi(hx));
            chk("in_ready_done", bus.in_ready == 1'b0, bus.in_ready, 0);
            bus.in_valid = k == 1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("valid_cleared", bus.out_valid == 1'b0, bus.out_valid, 0);
        send(8192, 6434, 4.0);
        drain();

        send(4096, 1000, 4.0);
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_out_valid", bus.out_valid == 1'b0, bus.out_valid, 0);
        chk("abort_out_X", bus.out_X == 0, bus.out_X, 0);
        chk("abort_out_Y", bus.out_Y == 0, bus.out_Y, 0);
        chk("abort_theta_res", bus.out_theta_res == 0, bus.out_theta_res, 0);
        chk("abort_in_ready", bus.in_ready == 1'b1, bus.in_ready, 1);
        void'(sb.pop_back());
        @(posedge clk);
        #2;
        rst = 1'b1;
        send(4096, -3217, 4.0);
        drain();

        send(16383, 3217, 6.0);
        for (int r = 0; r < 24; r++) begin
            m = int'($urandom_range(0, 32767)) - 16384;
            t = int'($urandom_range(0, 25736)) - 12868;
            send(m, t, 8.0 + ((m < 0 ? -m : m) / 1024));
        end
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cordic_rotate.md
Name: cordic_rotate

Overview:
Iterative rotation-mode CORDIC that converts polar (magnitude, angle) to rectangular (X, Y). It is the inverse direction of the pipelined vectoring CORDIC already in the datapath. It uses one shared micro-rotation datapath over 12 cycles, then a single gain-compensation multiply. A valid/ready handshake sits on both input and output, so it can sit downstream of the vectoring block or a host interface.

Parameters:
DATA_WIDTH, 15, width of all data ports; Q2.12 signed (1 sign, 2 integer, 12 fraction bits).
ITER, 12, number of micro-rotations; fixed at 12 to match the atan table.
GUARD, 2, extra integer bits on the internal X/Y registers to absorb CORDIC gain of about 1.647.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; asynchronous, active-low.
in_valid  input  1  input operand valid.
in_ready  output  1  block can accept an operand; high only in IDLE.
in_mag  input  DATA_WIDTH  signed magnitude, Q2.12.
in_theta  input  DATA_WIDTH  signed angle in radians, Q2.12, legal range [-12868, +12868] (±pi).
out_valid  output  1  result valid; held until accepted.
out_ready  input  1  consumer accepts result.
out_X  output  DATA_WIDTH  mag·cos(theta), Q2.12.
out_Y  output  DATA_WIDTH  mag·sin(theta), Q2.12.
out_theta_res  output  DATA_WIDTH  residual angle after the last iteration (convergence check).

Behaviour:
- Reset (rst=0, asynchronous):
  - state goes to IDLE.
  - out_valid=0; out_X, out_Y and out_theta_res are 0.
  - Internal x, y, z and the iteration counter are 0.
  - in_ready=1, since it is decoded as state==IDLE.
- A reset asserted mid-operation aborts the operation; no partial result is emitted.
- States: IDLE -> ROT -> SCALE -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge E0, load operands with quadrant pre-rotation and go to ROT with i=0.
- Pre-rotation (PI=12868, PI_2=6434):
  - theta > PI_2: z0 = theta - PI, x0 = -mag.
  - theta < -PI_2: z0 = theta + PI, x0 = -mag.
  - Otherwise: z0 = theta, x0 = mag.
  - y0 = 0 in all cases.
  - x and y are sign-extended to DATA_WIDTH+GUARD bits.
- ROT, one iteration per edge E1..E12:
  - d = +1 if z >= 0, else -1.
  - x' = x - d·(y >>> i); y' = y + d·(x >>> i); z' = z - d·ATAN[i].
  - Shifts are arithmetic and truncating.
  - ATAN = {3217, 1899, 1003, 509, 256, 128, 64, 32, 16, 8, 4, 2}.
  - After i=11, go to SCALE.
- SCALE, edge E13:
  - out_X = (x·K) >>> 12 and out_Y = (y·K) >>> 12, with K = 2487 (0.60725 in Q0.12).
  - Both are truncated, then saturated to the DATA_WIDTH signed range.
  - out_theta_res = z.
  - out_valid is set to 1 and the state goes to DONE.
- Latency: out_valid is high in the cycle after E13, i.e. 13 edges after the accept edge. Minimum issue interval is 15 cycles.
- DONE:
  - Outputs are held stable while out_valid=1 and out_ready=0.
  - On out_ready=1, clear out_valid and go to IDLE.
  - out_X and out_Y keep their last values.
  - A new operand can be accepted starting the following cycle.
- in_valid outside IDLE is ignored; the operand is not captured.
- in_theta outside ±PI: behaviour is undefined, but no lock-up is allowed; the FSM still completes the sequence.
- out_ready while out_valid=0 has no effect.

Decomposition:
- Package cordic_pkg holds:
  - ATAN table and ITER.
  - K_GAIN=2487, PI_Q=12868, PI_2_Q=6434.
  - The state enum {IDLE, ROT, SCALE, DONE}.
- Sub-module cordic_rot_iter: the combinational single micro-rotation (x, y, z, i, atan_i -> x', y', z'), reused every cycle.

Test Plan:
1. mag=4096, theta=0 -> out_X=4096±4, out_Y=0±4, |out_theta_res| <= 2; out_valid rises 13 edges after accept.
2. mag=4096, theta=3217 (pi/4) -> out_X=2896±4, out_Y=2896±4.
3. mag=4096, theta=-9651 (-3pi/4, pre-rotation path) -> out_X=-2896±4, out_Y=-2896±4; theta=12868 -> out_X=-4096±4, out_Y=0±4.
4. Hold out_ready=0 for 5 cycles after out_valid -> outputs and out_valid stable. Pulse in_valid during ROT and DONE -> in_ready=0 and the operand is ignored. The next IDLE accept with mag=8192, theta=6434 -> out_X=0±4, out_Y=8192±4.
5. Assert rst=0 asynchronously at iteration 6 -> out_valid=0 and all outputs 0 immediately; after release, in_ready=1 and a fresh operand completes correctly.
6. mag=16383, theta=3217 -> no internal overflow; out_X=out_Y=11585±6.
